// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage that sits directly after the ALU. It accepts a LOAD or
// STOR whose effective address was already computed upstream (reg1 + imm6).
// It runs a req/ack handshake with data memory and holds the core through
// `stall` while the access is outstanding. Load data is returned to the
// register-file write-back port as a one-cycle strobe.
//
// Optional feature (macro LSU_TIMEOUT_EN):
//   When defined, a BUSY watchdog aborts an access that has not been
//   acknowledged within TIMEOUT_CYCLES cycles. The abort sets the sticky
//   mem_error flag, and an aborted load writes back ERR_DATA.
//   When undefined, BUSY waits forever and mem_error is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles allowed without mem_ack (1..255, macro only)
//   ERR_DATA        write-back value for an aborted load (macro only)
//
// Ports:
//   clk         core clock
//   reset       asynchronous, active-low reset
//   clk_en      core advance enable; a new access starts only when high
//   load        decoded LOAD
//   store       decoded STOR
//   addr        effective byte address (passed through unmodified)
//   store_data  data to write
//   dest_reg    load destination register
//   mem_req     memory request, held until acknowledged
//   mem_we      1 = write, 0 = read; valid while mem_req
//   mem_addr    registered address
//   mem_wdata   registered write data
//   mem_ack     single-cycle completion pulse from memory
//   mem_rdata   read data, valid with mem_ack
//   stall       combinational hold request to the core
//   wb_valid    one-cycle write-back strobe for loads
//   wb_reg      write-back register index
//   wb_data     write-back data
//   mem_error   sticky abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int          TIMEOUT_CYCLES = 15,
   parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        load,
   input  logic        store,
   input  logic [15:0] addr,
   input  logic [15:0] store_data,
   input  logic [2:0]  dest_reg,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        stall,
   output logic        wb_valid,
   output logic [2:0]  wb_reg,
   output logic [15:0] wb_data,
   output logic        mem_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  wb_reg_q, wb_reg_d;
   logic [15:0] wb_data_q, wb_data_d;
   logic        wb_valid_q, wb_valid_d;

`ifdef LSU_TIMEOUT_EN
   // The counter holds the number of BUSY cycles already spent without an
   // ack. The access therefore expires in the cycle where it equals
   // TIMEOUT_CYCLES-1.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic        mem_error_q, mem_error_d;
`endif

   // Next-state and datapath capture for the access FSM
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_reg_d    = wb_reg_q;
      wb_data_d   = wb_data_q;
      wb_valid_d  = 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      mem_error_d = mem_error_q;
`endif

      case (state_q)
         IDLE: begin
            if (clk_en && (load || store)) begin
               mem_addr_d  = addr;
               mem_wdata_d = store_data;
               wb_reg_d    = dest_reg;
               // A load always wins when both decodes are high
               mem_we_d    = store & ~load;
               mem_req_d   = 1'b1;
               state_d     = BUSY;
`ifdef LSU_TIMEOUT_EN
               tmo_cnt_d   = 8'd0;
`endif
            end
         end

         BUSY: begin
            // An ack that arrives in the expiry cycle still completes normally
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = DONE;
               if (!mem_we_q) begin
                  wb_data_d  = mem_rdata;
                  wb_valid_d = 1'b1;
               end
            end
`ifdef LSU_TIMEOUT_EN
            else if (tmo_cnt_q == TIMEOUT_LAST) begin
               mem_req_d   = 1'b0;
               mem_error_d = 1'b1;
               state_d     = DONE;
               if (!mem_we_q) begin
                  wb_data_d  = ERR_DATA;
                  wb_valid_d = 1'b1;
               end
            end
            else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
`endif
         end

         // The same instruction is still presented while the core advances,
         // so load/store are deliberately ignored here.
         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 16'd0;
         mem_wdata_q <= 16'd0;
         wb_reg_q    <= 3'd0;
         wb_data_q   <= 16'd0;
         wb_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wb_reg_q    <= wb_reg_d;
         wb_data_q   <= wb_data_d;
         wb_valid_q  <= wb_valid_d;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q   <= 8'd0;
         mem_error_q <= 1'b0;
      end else begin
         tmo_cnt_q   <= tmo_cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign mem_error = mem_error_q;
`else
   assign mem_error = 1'b0;
`endif

   // The stall is gated by reset so the core is released while the unit is
   // held in reset, even if an instruction is still being presented.
   assign stall = reset & (((state_q == IDLE) & (load | store)) | (state_q == BUSY));

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_reg    = wb_reg_q;
   assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed test bench for load_store_unit. The bench drives inputs one time
// unit after each rising edge and checks outputs one time unit later, well
// away from the active edge. Every expected value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
   localparam int TMO = 3;
`else
   localparam int TMO = 15;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        load;
   logic        store;
   logic [15:0] addr;
   logic [15:0] store_data;
   logic [2:0]  dest_reg;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        wb_valid;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;
   logic        mem_error;

   int total = 0;
   int bad   = 0;
   int stall_cnt;
   int wbv_cnt;

   load_store_unit #(
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (16'hDEAD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .load       (load),
      .store      (store),
      .addr       (addr),
      .store_data (store_data),
      .dest_reg   (dest_reg),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .stall      (stall),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
      .mem_error  (mem_error)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on failure
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one instruction to the unit
   task automatic applyStimulus(input logic en, input logic ld, input logic st,
                                input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
      clk_en     = en;
      load       = ld;
      store      = st;
      addr       = a;
      store_data = d;
      dest_reg   = r;
   endtask

   // Advance to one time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);

      // ---------------- reset state ----------------
      #3;
      checkOutput("rst_mem_req",   16'(mem_req),   16'h0);
      checkOutput("rst_mem_we",    16'(mem_we),    16'h0);
      checkOutput("rst_mem_addr",  mem_addr,       16'h0);
      checkOutput("rst_mem_wdata", mem_wdata,      16'h0);
      checkOutput("rst_wb_valid",  16'(wb_valid),  16'h0);
      checkOutput("rst_wb_reg",    16'(wb_reg),    16'h0);
      checkOutput("rst_wb_data",   wb_data,        16'h0);
      checkOutput("rst_mem_error", 16'(mem_error), 16'h0);
      checkOutput("rst_stall",     16'(stall),     16'h0);
      tick();
      reset = 1'b1;
      tick();

      // ---------------- load, ack one cycle after mem_req ----------------
      stall_cnt = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'h5555, 3'd3);
      #1;
      checkOutput("ld_idle_stall", 16'(stall),   16'h1);
      checkOutput("ld_idle_req",   16'(mem_req), 16'h0);
      if (stall) stall_cnt++;
      tick();
      checkOutput("ld_busy_req",  16'(mem_req), 16'h1);
      checkOutput("ld_busy_we",   16'(mem_we),  16'h0);
      checkOutput("ld_busy_addr", mem_addr,     16'h0040);
      if (stall) stall_cnt++;
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      checkOutput("ld_done_req",   16'(mem_req),  16'h0);
      checkOutput("ld_done_wbv",   16'(wb_valid), 16'h1);
      checkOutput("ld_done_wbreg", 16'(wb_reg),   16'h3);
      checkOutput("ld_done_wbdat", wb_data,       16'hBEEF);
      checkOutput("ld_done_stall", 16'(stall),    16'h0);
      if (stall) stall_cnt++;
      checkOutput("ld_stall_cycles", 16'(stall_cnt), 16'd2);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
      #1;
      checkOutput("ld_after_wbv",   16'(wb_valid), 16'h0);
      checkOutput("ld_after_req",   16'(mem_req),  16'h0);
      checkOutput("ld_after_wbdat", wb_data,       16'hBEEF);

      // ---------------- store, ack after four BUSY cycles ----------------
      stall_cnt = 0;
      wbv_cnt   = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0102, 16'h1234, 3'd6);
      #1;
      if (stall) stall_cnt++;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput($sformatf("st_busy%0d_req", i),   16'(mem_req), 16'h1);
         checkOutput($sformatf("st_busy%0d_we", i),    16'(mem_we),  16'h1);
         checkOutput($sformatf("st_busy%0d_wdat", i),  mem_wdata,    16'h1234);
         checkOutput($sformatf("st_busy%0d_addr", i),  mem_addr,     16'h0102);
         if (stall) stall_cnt++;
         if (wb_valid) wbv_cnt++;
         if (i == 4) mem_ack = 1'b1;
      end
      tick();
      // DONE: keep a spurious ack and the same store presented; both ignored
      checkOutput("st_done_req",   16'(mem_req),  16'h0);
      checkOutput("st_done_stall", 16'(stall),    16'h0);
      if (stall) stall_cnt++;
      if (wb_valid) wbv_cnt++;
      tick();
      checkOutput("st_after_req", 16'(mem_req), 16'h0);
      if (wb_valid) wbv_cnt++;
      checkOutput("st_stall_cycles", 16'(stall_cnt), 16'd5);
      checkOutput("st_wbv_count",    16'(wbv_cnt),   16'd0);
      checkOutput("st_wbdat_kept",   wb_data,        16'hBEEF);

      // ---------------- spurious ack in IDLE ----------------
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("idle_ack_req",   16'(mem_req),  16'h0);
      checkOutput("idle_ack_wbv",   16'(wb_valid), 16'h0);
      checkOutput("idle_ack_stall", 16'(stall),    16'h0);

      // ---------------- load and store both high: load wins ----------------
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0200, 16'hAAAA, 3'd5);
      tick();
      checkOutput("both_req", 16'(mem_req), 16'h1);
      checkOutput("both_we",  16'(mem_we),  16'h0);
      mem_ack   = 1'b1;
      mem_rdata = 16'h0F0F;
      tick();
      mem_ack = 1'b0;
      checkOutput("both_wbv",   16'(wb_valid), 16'h1);
      checkOutput("both_wbreg", 16'(wb_reg),   16'h5);
      checkOutput("both_wbdat", wb_data,       16'h0F0F);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);

      // ---------------- load with clk_en low ----------------
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 3'd1);
      tick();
      checkOutput("noen_req",   16'(mem_req), 16'h0);
      checkOutput("noen_stall", 16'(stall),   16'h1);
      tick();
      checkOutput("noen_req2",  16'(mem_req), 16'h0);
      clk_en = 1'b1;
      tick();
      checkOutput("en_req",  16'(mem_req), 16'h1);
      checkOutput("en_addr", mem_addr,     16'h0300);
      mem_ack   = 1'b1;
      mem_rdata = 16'h7777;
      tick();
      mem_ack = 1'b0;
      checkOutput("en_wbdat", wb_data, 16'h7777);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);

      // ---------------- asynchronous reset mid-BUSY ----------------
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000, 3'd2);
      tick();
      checkOutput("arst_pre_req", 16'(mem_req), 16'h1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_req",   16'(mem_req),  16'h0);
      checkOutput("arst_stall", 16'(stall),    16'h0);
      checkOutput("arst_wbv",   16'(wb_valid), 16'h0);
      checkOutput("arst_addr",  mem_addr,      16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("arst_idle_req", 16'(mem_req), 16'h0);

      // ---------------- load with no ack ----------------
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0500, 16'h0000, 3'd4);
      tick();
`ifdef LSU_TIMEOUT_EN
      for (int i = 1; i <= 3; i++) begin
         checkOutput($sformatf("tmo_busy%0d_req", i), 16'(mem_req), 16'h1);
         tick();
      end
      checkOutput("tmo_req",   16'(mem_req),   16'h0);
      checkOutput("tmo_err",   16'(mem_error), 16'h1);
      checkOutput("tmo_wbv",   16'(wb_valid),  16'h1);
      checkOutput("tmo_wbdat", wb_data,        16'hDEAD);
      checkOutput("tmo_wbreg", 16'(wb_reg),    16'h4);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
      tick();
      checkOutput("tmo_err_sticky", 16'(mem_error), 16'h1);
      checkOutput("tmo_idle_wbv",   16'(wb_valid),  16'h0);
      reset = 1'b0;
      #1;
      checkOutput("tmo_err_cleared", 16'(mem_error), 16'h0);
      tick();
      reset = 1'b1;
`else
      for (int i = 1; i <= 22; i++) begin
         checkOutput($sformatf("hang%0d_req", i), 16'(mem_req), 16'h1);
         tick();
      end
      checkOutput("hang_err",   16'(mem_error), 16'h0);
      checkOutput("hang_wbv",   16'(wb_valid),  16'h0);
      checkOutput("hang_stall", 16'(stall),     16'h1);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
      #1;
      checkOutput("hang_rst_req", 16'(mem_req), 16'h0);
      tick();
      reset = 1'b1;
`endif
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
